// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer: borrows the shared ALU (ADD/SLL/SRL) for three
// cycles per multiplier bit and returns the low WIDTH bits of opA*opB.
module alu_mul_seq #(
   parameter int unsigned WIDTH      = 32,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_opA,
   input  logic [WIDTH-1:0] i_opB,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [3:0]       o_alu_ctrl,
   output logic [4:0]       o_alu_shift,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic             i_alu_zf
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   localparam logic [3:0] CtrlAdd = 4'b0010;
   localparam logic [3:0] CtrlSll = 4'b1000;
   localparam logic [3:0] CtrlSrl = 4'b1111;
   localparam logic [3:0] CtrlAnd = 4'b0000;

   typedef enum logic [2:0] {
      StIdle,
      StStep,
      StShl,
      StShr,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  result_q, result_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      o_alu_a     = '0;
      o_alu_b     = '0;
      o_alu_ctrl  = CtrlAnd;
      o_alu_shift = '0;
      o_busy      = 1'b1;
      o_done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            o_busy = 1'b0;
            if (i_start) begin
               acc_d    = '0;
               mcand_d  = i_opA;
               mplier_d = i_opB;
               cnt_d    = '0;
               state_d  = StStep;
            end
         end
         StStep: begin
            o_alu_a    = acc_q;
            o_alu_b    = mcand_q;
            o_alu_ctrl = CtrlAdd;
            if (mplier_q[0]) begin
               acc_d = i_alu_result;
            end
            state_d = StShl;
         end
         StShl: begin
            o_alu_b     = mcand_q;
            o_alu_ctrl  = CtrlSll;
            o_alu_shift = 5'd1;
            mcand_d     = i_alu_result;
            state_d     = StShr;
         end
         StShr: begin
            o_alu_b     = mplier_q;
            o_alu_ctrl  = CtrlSrl;
            o_alu_shift = 5'd1;
            mplier_d    = i_alu_result;
            cnt_d       = cnt_q + 1'b1;
            // zf here means no multiplier bits remain, so further steps add nothing
            if ((EARLY_EXIT && i_alu_zf) || (cnt_q == LastCnt)) begin
               result_d = acc_q;
               state_d  = StDone;
            end else begin
               state_d = StStep;
            end
         end
         StDone: begin
            o_done  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            o_busy  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   assign o_result = result_q;

endmodule
